// File: rtl/data_sram_responder.sv
//============================================================================
// Module      : data_sram_responder
// Description : Responder side of the CPU data-SRAM port. It decodes each
//               access into either an on-chip word RAM or a small confreg
//               block holding the LED, switch, timer and scratch registers.
//               Read data is registered and comes back exactly one cycle
//               after the access. Reads return the contents as they were
//               before any write made in the same cycle.
//
// Parameters  : ADDR_W     word-index width of the RAM (2**ADDR_W words)
//               CONF_BASE  base address of the confreg region
//               CONF_MASK  address bits compared against CONF_BASE
//
// Ports       : clk              clock, rising edge
//               reset            synchronous active-high reset
//               data_sram_en     access strobe
//               data_sram_wen    byte write enables (0 = read)
//               data_sram_addr   byte address, bits [1:0] ignored
//               data_sram_wdata  write data
//               data_sram_rdata  registered read data (access + 1 cycle)
//               switch_in        board switches
//               led_out          LED register
//               timer_out        free-running timer value
//
// Option      : CONFREG_TIMER_EN  define to build the 32-bit timer; when
//               undefined the timer offset reads 0 and timer_out is 0.
//
// Revision    : 1.0  initial release
//============================================================================
`default_nettype none

module data_sram_responder #(
    parameter int          ADDR_W    = 14,
    parameter logic [31:0] CONF_BASE = 32'hBFAF_0000,
    parameter logic [31:0] CONF_MASK = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch_in,
    output logic [15:0] led_out,
    output logic [31:0] timer_out
);

    localparam int c_DEPTH = 1 << ADDR_W;

    // Confreg word offsets (addr[15:2])
    localparam logic [13:0] c_OFF_LED     = 14'h0000;
    localparam logic [13:0] c_OFF_SWITCH  = 14'h0001;
    localparam logic [13:0] c_OFF_TIMER   = 14'h0002;
    localparam logic [13:0] c_OFF_SCRATCH = 14'h0003;

    // Replace the byte lanes selected by wen, keep the others.
    function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                            input logic [3:0]  wen,
                                            input logic [31:0] wdata);
        logic [31:0] v;
        v = old_val;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) begin
                v[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return v;
    endfunction

    //------------------------------------------------------------------------
    // Address decode
    //------------------------------------------------------------------------
    logic              w_conf_hit;
    logic              w_ram_hit;
    logic              w_write;
    logic [13:0]       w_conf_off;
    logic [ADDR_W-1:0] w_ram_idx;

    assign w_conf_hit = data_sram_en && ((data_sram_addr & CONF_MASK) == CONF_BASE);
    assign w_ram_hit  = data_sram_en && !w_conf_hit;
    // Accesses presented during reset are dropped entirely.
    assign w_write    = !reset && (data_sram_wen != 4'b0000);
    assign w_conf_off = data_sram_addr[15:2];
    // Upper address bits are ignored so the RAM aliases across the space.
    assign w_ram_idx  = data_sram_addr[ADDR_W+1:2];

    //------------------------------------------------------------------------
    // Word RAM (not reset)
    //------------------------------------------------------------------------
    logic [31:0] r_mem [c_DEPTH];
    logic [31:0] w_ram_rd;

    assign w_ram_rd = r_mem[w_ram_idx];

    always_ff @(posedge clk) begin
        if (w_ram_hit && w_write) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) begin
                    r_mem[w_ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    //------------------------------------------------------------------------
    // Confreg registers
    //------------------------------------------------------------------------
    logic [15:0] r_led;
    logic [31:0] r_scratch;
    logic [31:0] w_timer_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_led     <= 16'h0000;
            r_scratch <= 32'h0000_0000;
        end else if (w_conf_hit && w_write) begin
            if (w_conf_off == c_OFF_LED) begin
                // Only the low 16 bits exist; lanes 2/3 are discarded.
                if (data_sram_wen[0]) r_led[7:0]  <= data_sram_wdata[7:0];
                if (data_sram_wen[1]) r_led[15:8] <= data_sram_wdata[15:8];
            end
            if (w_conf_off == c_OFF_SCRATCH) begin
                r_scratch <= f_merge(r_scratch, data_sram_wen, data_sram_wdata);
            end
        end
    end

`ifdef CONFREG_TIMER_EN
    logic [31:0] r_timer;

    // A write loads the merged value in place of the increment for that edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= 32'h0000_0000;
        end else if (w_conf_hit && w_write && (w_conf_off == c_OFF_TIMER)) begin
            r_timer <= f_merge(r_timer, data_sram_wen, data_sram_wdata);
        end else begin
            r_timer <= r_timer + 32'd1;
        end
    end

    assign w_timer_val = r_timer;
`else
    assign w_timer_val = 32'h0000_0000;
`endif

    //------------------------------------------------------------------------
    // Confreg read mux
    //------------------------------------------------------------------------
    logic [31:0] w_conf_rd;

    always_comb begin
        w_conf_rd = 32'h0000_0000;
        case (w_conf_off)
            c_OFF_LED:     w_conf_rd = {16'h0000, r_led};
            c_OFF_SWITCH:  w_conf_rd = {24'h000000, switch_in};
            c_OFF_TIMER:   w_conf_rd = w_timer_val;
            c_OFF_SCRATCH: w_conf_rd = r_scratch;
            default:       w_conf_rd = 32'h0000_0000;
        endcase
    end

    //------------------------------------------------------------------------
    // Registered read data: holds while idle, read-before-write on access
    //------------------------------------------------------------------------
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= 32'h0000_0000;
        end else if (data_sram_en) begin
            r_rdata <= w_conf_hit ? w_conf_rd : w_ram_rd;
        end
    end

    assign data_sram_rdata = r_rdata;
    assign led_out         = r_led;
    assign timer_out       = w_timer_val;

endmodule

`default_nettype wire

// File: tb/tb_data_sram_responder.sv
//============================================================================
// Module      : tb_data_sram_responder
// Description : Self-checking bench for data_sram_responder. A behavioural
//               model keeps RAM words in an associative array and expresses
//               the timer as (load value + cycles since load).
// Revision    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_data_sram_responder;

    localparam logic [31:0] c_BASE = 32'hBFAF_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [7:0]  switch_in;
    logic [15:0] led_out;
    logic [31:0] timer_out;

    data_sram_responder dut (
        .clk             (clk),
        .reset           (reset),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .switch_in       (switch_in),
        .led_out         (led_out),
        .timer_out       (timer_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_mem [int];
    logic [15:0] m_led;
    logic [31:0] m_scratch;
    logic [31:0] m_tbase;
    int          m_tload;
    logic [31:0] m_rdata;
    bit          m_rvalid;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [3:0] w,
                                          input logic [31:0] d);
        logic [31:0] v;
        v = o;
        for (int i = 0; i < 4; i++) if (w[i]) v[8*i +: 8] = d[8*i +: 8];
        return v;
    endfunction

    // Timer value right after edge k.
    function automatic logic [31:0] tmr_at(input int k);
`ifdef CONFREG_TIMER_EN
        return m_tbase + 32'(k - m_tload);
`else
        return 32'h0 + 32'(k - k);
`endif
    endfunction

    // One access cycle; returns the model's rdata after the edge.
    task automatic access(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] exp, output bit valid);
        logic [31:0] rd;
        logic [31:0] tmp;
        bit          rv;
        int          n;
        int          idx;
        data_sram_en    = en;
        data_sram_wen   = wen;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
        @(posedge clk);
        #1;
        n = cyc;
        if (en) begin
            rd = 32'h0;
            rv = 1'b1;
            if ((addr & 32'hFFFF_0000) == c_BASE) begin
                case (addr[15:0] / 4)
                    0: rd = {16'h0, m_led};
                    1: rd = {24'h0, switch_in};
                    2: rd = tmr_at(n - 1);
                    3: rd = m_scratch;
                    default: rd = 32'h0;
                endcase
                if (wen != 4'h0) begin
                    case (addr[15:0] / 4)
                        0: begin
                            tmp   = merge({16'h0, m_led}, wen, wdata);
                            m_led = tmp[15:0];
                        end
                        2: begin
`ifdef CONFREG_TIMER_EN
                            m_tbase = merge(tmr_at(n - 1), wen, wdata);
                            m_tload = n;
`endif
                        end
                        3: m_scratch = merge(m_scratch, wen, wdata);
                        default: ;
                    endcase
                end
            end else begin
                idx = int'((addr / 4) % 16384);
                if (m_mem.exists(idx)) rd = m_mem[idx];
                else rv = 1'b0;
                if (wen == 4'hF) m_mem[idx] = wdata;
                else if (wen != 4'h0 && m_mem.exists(idx)) m_mem[idx] = merge(m_mem[idx], wen, wdata);
            end
            m_rdata  = rd;
            m_rvalid = rv;
        end
        exp   = m_rdata;
        valid = m_rvalid;
    endtask

    task automatic test_reset();
        logic [31:0] e;
        bit          v;
        reset = 1'b1;
        data_sram_en = 1'b0; data_sram_wen = 4'h0; data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
        switch_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        m_led = 16'h0; m_scratch = 32'h0; m_tbase = 32'h0; m_tload = cyc;
        m_rdata = 32'h0; m_rvalid = 1'b1;
        checks++;
        if (data_sram_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata got %h want %h", data_sram_rdata, 32'h0);
        end
        access(1'b1, 4'hF, 32'h10, 32'hCAFE_F00D, e, v);
        // Reset cycle carrying a write to the same word: must be dropped.
        reset = 1'b1;
        data_sram_en = 1'b1; data_sram_wen = 4'hF; data_sram_addr = 32'h10; data_sram_wdata = 32'hBADB_AD00;
        @(posedge clk);
        #1;
        reset = 1'b0;
        data_sram_en = 1'b0;
        m_led = 16'h0; m_scratch = 32'h0; m_tbase = 32'h0; m_tload = cyc;
        m_rdata = 32'h0; m_rvalid = 1'b1;
        checks++;
        if (data_sram_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_access_rdata got %h want %h", data_sram_rdata, 32'h0);
        end
        checks++;
        if (led_out !== 16'h0 || timer_out !== 32'h0) begin
            errors++; $display("FAIL reset_regs led %h timer %h want 0 0", led_out, timer_out);
        end
        access(1'b1, 4'h0, 32'h10, 32'h0, e, v);
        checks++;
        if (data_sram_rdata !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL reset_no_write got %h want %h", data_sram_rdata, 32'hCAFE_F00D);
        end
    endtask

    task automatic test_partial_write();
        logic [31:0] e;
        bit          v;
        access(1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF, e, v);
        access(1'b1, 4'b0001, 32'h100, 32'h0000_00AA, e, v);
        access(1'b1, 4'h0, 32'h100, 32'h0, e, v);
        checks++;
        if (data_sram_rdata !== 32'hDEAD_BEAA) begin
            errors++; $display("FAIL partial_write got %h want %h", data_sram_rdata, 32'hDEAD_BEAA);
        end
    endtask

    task automatic test_read_before_write();
        logic [31:0] e;
        bit          v;
        access(1'b1, 4'hF, 32'h0, 32'h1111_1111, e, v);
        access(1'b1, 4'h0, 32'h0, 32'h0, e, v);
        checks++;
        if (data_sram_rdata !== 32'h1111_1111) begin
            errors++; $display("FAIL b2b_read got %h want %h", data_sram_rdata, 32'h1111_1111);
        end
        access(1'b1, 4'hF, 32'h0, 32'h2222_2222, e, v);
        checks++;
        if (data_sram_rdata !== 32'h1111_1111) begin
            errors++; $display("FAIL rbw_old_data got %h want %h", data_sram_rdata, 32'h1111_1111);
        end
        access(1'b0, 4'h0, 32'h0, 32'h0, e, v);
        checks++;
        if (data_sram_rdata !== 32'h1111_1111) begin
            errors++; $display("FAIL idle_hold got %h want %h", data_sram_rdata, 32'h1111_1111);
        end
        access(1'b1, 4'h0, 32'h0, 32'h0, e, v);
        checks++;
        if (data_sram_rdata !== 32'h2222_2222) begin
            errors++; $display("FAIL rbw_new_data got %h want %h", data_sram_rdata, 32'h2222_2222);
        end
    endtask

    task automatic test_confreg();
        logic [31:0] e;
        bit          v;
        switch_in = 8'h5A;
        access(1'b1, 4'hF, c_BASE, 32'hFFFF_1234, e, v);
        checks++;
        if (led_out !== 16'h1234) begin
            errors++; $display("FAIL led_out got %h want %h", led_out, 16'h1234);
        end
        access(1'b1, 4'h0, c_BASE, 32'h0, e, v);
        checks++;
        if (data_sram_rdata !== 32'h0000_1234) begin
            errors++; $display("FAIL led_read got %h want %h", data_sram_rdata, 32'h0000_1234);
        end
        access(1'b1, 4'hF, c_BASE + 32'h4, 32'hFFFF_FFFF, e, v);
        checks++;
        if (data_sram_rdata !== 32'h0000_005A) begin
            errors++; $display("FAIL switch_read got %h want %h", data_sram_rdata, 32'h0000_005A);
        end
        access(1'b1, 4'hF, c_BASE + 32'hC, 32'h0102_0304, e, v);
        access(1'b1, 4'b0110, c_BASE + 32'hC, 32'hAABB_CCDD, e, v);
        access(1'b1, 4'h0, c_BASE + 32'hC, 32'h0, e, v);
        checks++;
        if (data_sram_rdata !== 32'h01BB_CC04) begin
            errors++; $display("FAIL scratch_merge got %h want %h", data_sram_rdata, 32'h01BB_CC04);
        end
        access(1'b1, 4'hF, c_BASE + 32'h10, 32'h1234_5678, e, v);
        access(1'b1, 4'h0, c_BASE + 32'h10, 32'h0, e, v);
        checks++;
        if (data_sram_rdata !== 32'h0) begin
            errors++; $display("FAIL unmapped_read got %h want %h", data_sram_rdata, 32'h0);
        end
    endtask

    task automatic test_timer();
        logic [31:0] e;
        bit          v;
        logic [31:0] want [3];
        access(1'b1, 4'hF, c_BASE + 32'h8, 32'hFFFF_FFFE, e, v);
`ifdef CONFREG_TIMER_EN
        want[0] = 32'hFFFF_FFFF; want[1] = 32'h0000_0000; want[2] = 32'h0000_0001;
        checks++;
        if (timer_out !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL timer_load got %h want %h", timer_out, 32'hFFFF_FFFE);
        end
        for (int i = 0; i < 3; i++) begin
            access(1'b0, 4'h0, 32'h0, 32'h0, e, v);
            checks++;
            if (timer_out !== want[i]) begin
                errors++; $display("FAIL timer_wrap[%0d] got %h want %h", i, timer_out, want[i]);
            end
        end
        access(1'b1, 4'h0, c_BASE + 32'h8, 32'h0, e, v);
        checks++;
        if (data_sram_rdata !== 32'h0000_0001) begin
            errors++; $display("FAIL timer_read got %h want %h", data_sram_rdata, 32'h1);
        end
`else
        want[0] = 32'h0; want[1] = 32'h0; want[2] = 32'h0;
        access(1'b1, 4'h0, c_BASE + 32'h8, 32'h0, e, v);
        checks++;
        if (data_sram_rdata !== want[0]) begin
            errors++; $display("FAIL timer_read got %h want %h", data_sram_rdata, want[0]);
        end
        for (int i = 1; i < 3; i++) begin
            access(1'b0, 4'h0, 32'h0, 32'h0, e, v);
            checks++;
            if (timer_out !== want[i]) begin
                errors++; $display("FAIL timer_idle[%0d] got %h want %h", i, timer_out, want[i]);
            end
        end
`endif
    endtask

    task automatic test_alias();
        logic [31:0] e;
        bit          v;
        access(1'b1, 4'hF, 32'h0004_0010, 32'h5555_AAAA, e, v);
        access(1'b1, 4'h0, 32'h0000_0010, 32'h0, e, v);
        checks++;
        if (data_sram_rdata !== 32'h5555_AAAA) begin
            errors++; $display("FAIL alias got %h want %h", data_sram_rdata, 32'h5555_AAAA);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        bit          v;
        logic [31:0] addr;
        logic [15:0] up;
        logic [3:0]  wen;
        int          cat;
        for (int k = 0; k < 16; k++) access(1'b1, 4'hF, 32'h200 + 32'(4 * k), $urandom, e, v);
        for (int it = 0; it < 300; it++) begin
            switch_in = 8'($urandom);
            cat = int'($urandom_range(0, 9));
            wen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            case ($urandom_range(0, 2))
                0: up = 16'h0000;
                1: up = 16'h0004;
                default: up = 16'h8001;
            endcase
            if (cat <= 5) addr = {up, 16'h0200 + 16'(4 * $urandom_range(0, 15))} | 32'($urandom_range(0, 3));
            else addr = c_BASE + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
            access(cat != 9, wen, addr, $urandom, e, v);
            if (v) begin
                checks++;
                if (data_sram_rdata !== e) begin
                    errors++; $display("FAIL rand_rdata[%0d] addr %h got %h want %h", it, addr, data_sram_rdata, e);
                end
            end
            checks++;
            if (led_out !== m_led || timer_out !== tmr_at(cyc)) begin
                errors++; $display("FAIL rand_regs[%0d] led %h/%h timer %h/%h", it, led_out, m_led,
                                   timer_out, tmr_at(cyc));
            end
        end
    endtask

    initial begin
        test_reset();
        test_partial_write();
        test_read_before_write();
        test_confreg();
        test_timer();
        test_alias();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
